// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner of the RTC multiplexed address/data bus.
// Serves a periodic register reader and a configuration writer. Each access
// is an address phase and a data phase, each followed by a strobes-high gap.
module rtc_bus_arbiter #(
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_r,
  input  logic [7:0] addr_r,
  output logic       ack_r,
  output logic [7:0] rdata,
  input  logic       req_w,
  input  logic [7:0] addr_w,
  input  logic [7:0] wdata,
  output logic       ack_w,
  output logic       busy,
  inout  wire  [7:0] dato,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr
);

  localparam int unsigned T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_GAP,
    DATA,
    DATA_GAP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant_w;  // 0 = last grant went to the reader
  logic             is_write;
  logic [7:0]       wdata_q;
  logic [7:0]       dato_q;
  logic             drive_en;
  logic             grant_w_c;

  // Writer wins when it is alone or when the reader was served last.
  assign grant_w_c = req_w & (~req_r | ~last_grant_w);

  // Pin driver: released whenever the bus belongs to the RTC.
  assign dato = drive_en ? dato_q : 8'hzz;

  // Access sequencer with registered strobes, bus drive and handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant_w <= 1'b0;
      is_write     <= 1'b0;
      wdata_q      <= '0;
      dato_q       <= '0;
      drive_en     <= 1'b0;
      cs           <= 1'b1;
      rd           <= 1'b1;
      wr           <= 1'b1;
      a_d          <= 1'b1;
      ack_r        <= 1'b0;
      ack_w        <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_r || req_w) begin
            is_write     <= grant_w_c;
            last_grant_w <= grant_w_c;
            wdata_q      <= wdata;
            dato_q       <= grant_w_c ? addr_w : addr_r;
            drive_en     <= 1'b1;
            a_d          <= 1'b0;
            cs           <= 1'b0;
            wr           <= 1'b0;
            rd           <= 1'b1;
            busy         <= 1'b1;
            cnt          <= CNT_W'(T_PULSE - 1);
            state        <= ADDR;
          end
        end

        ADDR: begin
          if (cnt == '0) begin
            cs    <= 1'b1;
            wr    <= 1'b1;
            cnt   <= CNT_W'(T_GAP - 1);
            state <= ADDR_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ADDR_GAP: begin
          if (cnt == '0) begin
            a_d <= 1'b1;
            cs  <= 1'b0;
            if (is_write) begin
              wr     <= 1'b0;
              dato_q <= wdata_q;
            end else begin
              rd       <= 1'b0;
              drive_en <= 1'b0;
            end
            cnt   <= CNT_W'(T_PULSE - 1);
            state <= DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            cs <= 1'b1;
            wr <= 1'b1;
            rd <= 1'b1;
            if (!is_write) begin
              rdata <= dato;
            end
            cnt   <= CNT_W'(T_GAP - 1);
            state <= DATA_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA_GAP: begin
          if (cnt == '0) begin
            drive_en <= 1'b0;
            ack_w    <= is_write;
            ack_r    <= ~is_write;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          ack_r <= 1'b0;
          ack_w <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          drive_en <= 1'b0;
          cs       <= 1'b1;
          rd       <= 1'b1;
          wr       <= 1'b1;
          a_d      <= 1'b1;
          ack_r    <= 1'b0;
          ack_w    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: an RTC register-file pin model, a reference
// memory/arbitration model, and directed plus random request streams.
module tb_rtc_bus_arbiter;

  localparam int unsigned TP = 10;
  localparam int unsigned TG = 4;

  logic       clk;
  logic       reset;
  logic       req_r, req_w;
  logic [7:0] addr_r, addr_w, wdata;
  logic       ack_r, ack_w, busy;
  logic [7:0] rdata;
  logic       a_d, cs, rd, wr;
  tri0  [7:0] dato;   // pin pulldowns give a released bus a known 0

  // Second instance with the shortest legal timing.
  logic       req_r_f, req_w_f;
  logic [7:0] addr_r_f, addr_w_f, wdata_f;
  logic       ack_r_f, ack_w_f, busy_f;
  logic [7:0] rdata_f;
  logic       a_d_f, cs_f, rd_f, wr_f;
  tri0  [7:0] dato_f;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  rtc_bus_arbiter #(.T_PULSE(TP), .T_GAP(TG)) dut (
    .clk(clk), .reset(reset),
    .req_r(req_r), .addr_r(addr_r), .ack_r(ack_r), .rdata(rdata),
    .req_w(req_w), .addr_w(addr_w), .wdata(wdata), .ack_w(ack_w),
    .busy(busy), .dato(dato), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr)
  );

  rtc_bus_arbiter #(.T_PULSE(1), .T_GAP(1)) dut_f (
    .clk(clk), .reset(reset),
    .req_r(req_r_f), .addr_r(addr_r_f), .ack_r(ack_r_f), .rdata(rdata_f),
    .req_w(req_w_f), .addr_w(addr_w_f), .wdata(wdata_f), .ack_w(ack_w_f),
    .busy(busy_f), .dato(dato_f), .a_d(a_d_f), .cs(cs_f), .rd(rd_f), .wr(wr_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RTC pin model (main instance) ----------------
  bit   [7:0] rtc_mem     [256];
  bit         rtc_written [256];
  logic [7:0] seen_addr, seen_wdat, rtc_rd_val;
  int         addr_cnt, agap_cnt, wdat_cnt, rdat_cnt, dgap_cnt, viol;
  logic       prev_cs = 1'b1, prev_a_d = 1'b1;

  // Unwritten registers read back as address + 0x37.
  assign rtc_rd_val = rtc_written[seen_addr] ? rtc_mem[seen_addr] : 8'(seen_addr + 8'h37);
  assign dato       = (rd == 1'b0) ? rtc_rd_val : 8'hzz;
  assign dato_f     = (rd_f == 1'b0) ? 8'h3C : 8'hzz;

  // Per-access phase bookkeeping and bus-rule watch.
  always @(negedge clk) begin
    if (!busy) begin
      addr_cnt <= 0; agap_cnt <= 0; wdat_cnt <= 0;
      rdat_cnt <= 0; dgap_cnt <= 0; viol <= 0;
      if (cs !== 1'b1 || rd !== 1'b1 || wr !== 1'b1 || dato !== 8'h00) viol <= 32;
    end else begin
      if (!cs && !a_d) begin
        addr_cnt  <= addr_cnt + 1;
        seen_addr <= dato;
        if (wr !== 1'b0 || rd !== 1'b1) viol <= viol | 1;
      end
      if (cs && !a_d) begin
        agap_cnt <= agap_cnt + 1;
        if (dato !== seen_addr || rd !== 1'b1 || wr !== 1'b1) viol <= viol | 2;
      end
      if (!cs && a_d && !wr) begin
        wdat_cnt               <= wdat_cnt + 1;
        seen_wdat              <= dato;
        rtc_mem[seen_addr]     <= dato;
        rtc_written[seen_addr] <= 1'b1;
      end
      if (!cs && a_d && !rd) rdat_cnt <= rdat_cnt + 1;
      if (cs && a_d && !(ack_r || ack_w)) begin
        dgap_cnt <= dgap_cnt + 1;
        if ((wdat_cnt != 0) ? (dato !== seen_wdat) : (dato !== 8'h00)) viol <= viol | 4;
      end
      if ((ack_r || ack_w) && (dato !== 8'h00 || cs !== 1'b1)) viol <= viol | 8;
    end
    if ((!rd && !wr) || (!cs && !prev_cs && (a_d != prev_a_d))) viol <= viol | 16;
    prev_cs  <= cs;
    prev_a_d <= a_d;
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem     [256];
  bit         ref_written [256];
  bit         model_last_w = 1'b0;
  logic [7:0] model_rdata  = 8'h00;

  function automatic logic [7:0] ref_val(input logic [7:0] a);
    return ref_written[a] ? ref_mem[a] : 8'(a + 8'h37);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_addr();
    return 8'(8'h20 + $urandom_range(0, 7));
  endfunction

  // Runs n accesses; each requester re-raises in the bubble after its ack.
  task automatic run_stream(input int n, input bit en_r, input bit en_w, input bit fixed,
                            input logic [7:0] far, input logic [7:0] faw, input logic [7:0] fwd);
    int         raised, got, t_prev, lat_exp, guard;
    bit         pend_r, pend_w, win_w, seen;
    logic [7:0] a_r, a_w, d_w, exp_r;
    guard = 0;
    while (busy && guard < 100) begin tick(); guard++; end
    check("idle_before_stream", 32'(busy), 32'(0));
    raised = 0; got = 0; pend_r = 0; pend_w = 0;
    a_r = 8'h00; a_w = 8'h00; d_w = 8'h00;
    if (en_w) begin
      a_w = fixed ? faw : rand_addr(); d_w = fixed ? fwd : 8'($urandom);
      addr_w = a_w; wdata = d_w; req_w = 1'b1; pend_w = 1; raised++;
    end
    if (en_r && raised < n) begin
      a_r = fixed ? far : rand_addr();
      addr_r = a_r; req_r = 1'b1; pend_r = 1; raised++;
    end
    t_prev  = cyc;
    lat_exp = 1 + 2 * int'(TP + TG);
    while (got < n) begin
      win_w = pend_w && (!pend_r || !model_last_w);
      seen  = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (ack_r || ack_w) begin seen = 1; break; end
      end
      check("ack_arrives", 32'(seen), 32'(1));
      if (!seen) begin req_r = 1'b0; req_w = 1'b0; return; end
      check("ack_owner", 32'({ack_w, ack_r}), win_w ? 32'(2) : 32'(1));
      check("ack_latency", 32'(cyc - t_prev), 32'(lat_exp));
      check("busy_at_ack", 32'(busy), 32'(1));
      check("addr_low_cycles", 32'(addr_cnt), 32'(TP));
      check("addr_gap_cycles", 32'(agap_cnt), 32'(TG));
      check("data_gap_cycles", 32'(dgap_cnt), 32'(TG));
      check("bus_rules", 32'(viol), 32'(0));
      if (win_w) begin
        check("wr_addr_on_bus", 32'(seen_addr), 32'(a_w));
        check("wr_data_on_bus", 32'(seen_wdat), 32'(d_w));
        check("wr_data_cycles", 32'(wdat_cnt), 32'(TP));
        check("no_rd_in_write", 32'(rdat_cnt), 32'(0));
        check("rdata_held", 32'(rdata), 32'(model_rdata));
        ref_mem[a_w] = d_w; ref_written[a_w] = 1'b1;
        req_w = 1'b0; pend_w = 0;
      end else begin
        exp_r = ref_val(a_r);
        check("rd_addr_on_bus", 32'(seen_addr), 32'(a_r));
        check("rd_data_cycles", 32'(rdat_cnt), 32'(TP));
        check("no_wr_in_read", 32'(wdat_cnt), 32'(0));
        check("rdata", 32'(rdata), 32'(exp_r));
        model_rdata = exp_r;
        req_r = 1'b0; pend_r = 0;
      end
      model_last_w = win_w;
      got++;
      t_prev  = cyc;
      lat_exp = 2 + 2 * int'(TP + TG);
      tick();
      check("bubble_after_ack", 32'({ack_w, ack_r, busy}), 32'(0));
      if (raised < n) begin
        if (win_w && en_w) begin
          a_w = fixed ? faw : rand_addr(); d_w = fixed ? fwd : 8'($urandom);
          addr_w = a_w; wdata = d_w; req_w = 1'b1; pend_w = 1; raised++;
        end else if (!win_w && en_r) begin
          a_r = fixed ? far : rand_addr();
          addr_r = a_r; req_r = 1'b1; pend_r = 1; raised++;
        end
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(); tick();
    check("rst_strobes", 32'({cs, rd, wr, a_d}), 32'(4'hF));
    check("rst_handshake", 32'({ack_r, ack_w, busy}), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_bus_released", 32'(dato), 32'(0));
    reset = 1'b0;
    model_last_w = 1'b0;
    model_rdata  = 8'h00;
    tick();
  endtask

  initial begin
    int         t0, guard, lowa, lowd;
    bit         seen;
    logic [7:0] rnd;
    reset = 1'b1;
    req_r = 0; req_w = 0; addr_r = 0; addr_w = 0; wdata = 0;
    req_r_f = 0; req_w_f = 0; addr_r_f = 0; addr_w_f = 0; wdata_f = 0;

    // Reset state, then a single write and a single read.
    apply_reset();
    run_stream(1, 0, 1, 1, 8'h00, 8'h21, 8'h45);
    run_stream(1, 1, 0, 1, 8'h22, 8'h00, 8'h00);
    check("read_0x22", 32'(rdata), 32'(8'h59));

    // Simultaneous requests out of reset, then a held pair alternating.
    apply_reset();
    run_stream(2, 1, 1, 1, 8'h21, 8'h23, 8'hA7);
    run_stream(6, 1, 1, 0, 8'h00, 8'h00, 8'h00);

    // Reset pulsed during the data phase of a write.
    guard = 0;
    while (busy && guard < 100) begin tick(); guard++; end
    addr_w = 8'h30; wdata = 8'h6B; req_w = 1'b1;
    t0 = cyc;
    guard = 0;
    while (cyc < t0 + 1 + int'(TP + TG) + 3 && guard < 100) begin tick(); guard++; end
    check("in_write_data", 32'({cs, wr, a_d}), 32'(3'b001));
    reset = 1'b1;
    #1;
    check("async_rst_strobes", 32'({cs, rd, wr, a_d}), 32'(4'hF));
    check("async_rst_bus", 32'(dato), 32'(0));
    req_w = 1'b0;
    #1;
    reset = 1'b0;
    model_last_w = 1'b0;
    model_rdata  = 8'h00;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack_w || ack_r || busy) seen = 1;
    end
    check("no_ack_after_abort", 32'(seen), 32'(0));
    run_stream(1, 0, 1, 1, 8'h00, 8'h30, 8'h6B);
    run_stream(1, 1, 0, 1, 8'h30, 8'h00, 8'h00);

    // Random request streams.
    for (int s = 0; s < 6; s++) begin
      rnd = 8'($urandom_range(1, 3));
      run_stream(int'($urandom_range(1, 5)), rnd[0], rnd[1], 0, 8'h00, 8'h00, 8'h00);
    end

    // Shortest timing: one-cycle strobes, ack five cycles after the request.
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin addr_w_f = 8'h10; wdata_f = 8'h77; req_w_f = 1'b1; end
      else begin addr_r_f = 8'h11; req_r_f = 1'b1; end
      t0 = cyc; lowa = 0; lowd = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (!cs_f && !a_d_f) lowa++;
        if (!cs_f && a_d_f) lowd++;
        if (ack_w_f || ack_r_f) begin seen = 1; break; end
      end
      check("fast_ack", 32'({ack_w_f, ack_r_f}), (t == 0) ? 32'(2) : 32'(1));
      check("fast_latency", 32'(cyc - t0), 32'(5));
      check("fast_addr_low", 32'(lowa), 32'(1));
      check("fast_data_low", 32'(lowd), 32'(1));
      check("fast_rdata", 32'(rdata_f), (t == 0) ? 32'(0) : 32'(8'h3C));
      req_w_f = 1'b0; req_r_f = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
